// File: rtl/ofs_fim_pcie_ss_ib2sb_block_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ofs_fim_pcie_ss_ib2sb_block_pkg: shared PCIe SS header constants  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ofs_fim_pcie_ss_ib2sb_block_pkg;
   localparam int HDR_W     = 256;
   localparam int HDR_BYTES = HDR_W / 8;
endpackage
`default_nettype wire

// File: rtl/ofs_fim_pcie_ss_ib2sb_block_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pcie_ss_axis_if: AXI-stream TLP bus with vendor user bits          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface pcie_ss_axis_if #(
   parameter int DATA_W = 512,
   parameter int USER_W = 1
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_W-1:0]     tdata;
   logic [DATA_W/8-1:0]   tkeep;
   logic                  tlast;
   logic [USER_W-1:0]     tuser_vendor;

   modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
   modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface
`default_nettype wire

// File: rtl/ofs_fim_pcie_ss_ib2sb_block.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ofs_fim_pcie_ss_ib2sb_block: in-band header to side-band header    |
// | TLP stream converter. Revision: 1.0                                |
// +--------------------------------------------------------------------+
module ofs_fim_pcie_ss_ib2sb_block
   import ofs_fim_pcie_ss_ib2sb_block_pkg::*;
#(
   parameter int DATA_W = 512
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   pcie_ss_axis_if.sink    stream_in,
   pcie_ss_axis_if.source  stream_out
);
   localparam int KEEP_W = DATA_W / 8;
   localparam int UP_W   = DATA_W - HDR_W;
   localparam int UPK_W  = KEEP_W - HDR_BYTES;

   typedef enum logic [1:0] {
      ST_SOP   = 2'd0,
      ST_BODY  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic [KEEP_W-1:0]   r_out_keep;
   logic                r_out_last;
   logic [HDR_W:0]      r_out_user;

   logic [UP_W-1:0]     r_hold_data;
   logic [UPK_W-1:0]    r_hold_keep;
   logic [HDR_W-1:0]    r_hdr;
   logic                r_vendor;
   logic                r_first;

   logic                w_out_free;
   logic                w_in_ready;
   logic                w_in_acc;
   logic                w_tail_empty;
   logic                w_emit;
   logic                w_sop_ld;
   logic                w_hold_ld;
   logic [DATA_W-1:0]   w_nd;
   logic [KEEP_W-1:0]   w_nk;
   logic                w_nl;
   logic [HDR_W:0]      w_nu;

   // in tready depends only on registered state and the downstream ready
   assign w_out_free      = !r_out_valid || stream_out.tready;
   assign w_in_ready      = w_out_free && (r_state != ST_FLUSH);
   assign w_in_acc        = stream_in.tvalid && w_in_ready;
   assign w_tail_empty    = (stream_in.tkeep[KEEP_W-1:HDR_BYTES] == '0);
   assign stream_in.tready = w_in_ready;

   assign stream_out.tvalid       = r_out_valid;
   assign stream_out.tdata        = r_out_data;
   assign stream_out.tkeep        = r_out_keep;
   assign stream_out.tlast        = r_out_last;
   assign stream_out.tuser_vendor = r_out_user;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_SOP;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_emit)
            r_out_valid <= 1'b1;
         else if (stream_out.tready)
            r_out_valid <= 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_sop_ld    = 1'b0;
      w_hold_ld   = 1'b0;
      w_nd        = '0;
      w_nk        = '0;
      w_nl        = 1'b0;
      w_nu        = '0;
      case (r_state)
         ST_SOP: begin
            if (w_in_acc) begin
               w_sop_ld  = 1'b1;
               w_hold_ld = 1'b1;
               if (stream_in.tlast) begin
                  // single-beat packet: header-only forces an all-zero data beat
                  w_emit = 1'b1;
                  w_nd   = w_tail_empty ? '0 :
                           {{HDR_W{1'b0}}, stream_in.tdata[DATA_W-1:HDR_W]};
                  w_nk   = {{HDR_BYTES{1'b0}}, stream_in.tkeep[KEEP_W-1:HDR_BYTES]};
                  w_nl   = 1'b1;
                  w_nu   = {stream_in.tdata[HDR_W-1:0], stream_in.tuser_vendor[0]};
               end else begin
                  w_state_nxt = ST_BODY;
               end
            end
         end
         ST_BODY: begin
            if (w_in_acc) begin
               w_emit    = 1'b1;
               w_hold_ld = 1'b1;
               w_nd      = {stream_in.tdata[HDR_W-1:0], r_hold_data};
               w_nk      = {stream_in.tkeep[HDR_BYTES-1:0], r_hold_keep};
               w_nl      = stream_in.tlast && w_tail_empty;
               w_nu      = r_first ? {r_hdr, r_vendor} : {{HDR_W{1'b0}}, r_vendor};
               if (stream_in.tlast)
                  w_state_nxt = w_tail_empty ? ST_SOP : ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (w_out_free) begin
               w_emit      = 1'b1;
               w_nd        = {{HDR_W{1'b0}}, r_hold_data};
               w_nk        = {{HDR_BYTES{1'b0}}, r_hold_keep};
               w_nl        = 1'b1;
               w_nu        = {{HDR_W{1'b0}}, r_vendor};
               w_state_nxt = ST_SOP;
            end
         end
         default: w_state_nxt = ST_SOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_emit) begin
         r_out_data <= w_nd;
         r_out_keep <= w_nk;
         r_out_last <= w_nl;
         r_out_user <= w_nu;
      end
      if (w_hold_ld) begin
         r_hold_data <= stream_in.tdata[DATA_W-1:HDR_W];
         r_hold_keep <= stream_in.tkeep[KEEP_W-1:HDR_BYTES];
      end
      if (w_sop_ld) begin
         r_hdr    <= stream_in.tdata[HDR_W-1:0];
         r_vendor <= stream_in.tuser_vendor[0];
         r_first  <= 1'b1;
      end else if (w_emit) begin
         r_first  <= 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ofs_fim_pcie_ss_ib2sb_block.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ofs_fim_pcie_ss_ib2sb_block: scoreboard bench for ib2sb block   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_ofs_fim_pcie_ss_ib2sb_block;
   localparam int DW = 512;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic [256:0]  u;
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pcie_ss_axis_if #(.DATA_W(DW), .USER_W(1))   in_if ();
   pcie_ss_axis_if #(.DATA_W(DW), .USER_W(257)) out_if ();

   ofs_fim_pcie_ss_ib2sb_block #(.DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stream_in  (in_if),
      .stream_out (out_if)
   );

   beat_t sb[$];
   int    n_chk    = 0;
   int    n_fail   = 0;
   int    rdy_mode = 2;   // 0: low 1 cycle in 16, 1: held low, 2: held high

   initial begin
      in_if.tvalid       = 1'b0;
      in_if.tdata        = '0;
      in_if.tkeep        = '0;
      in_if.tlast        = 1'b0;
      in_if.tuser_vendor = '0;
      out_if.tready      = 1'b1;
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1:       out_if.tready = 1'b0;
         2:       out_if.tready = 1'b1;
         default: out_if.tready = ($urandom_range(15) != 0);
      endcase
   end

   // output beats are taken at the next rising edge; compare them mid-cycle
   always @(negedge clk) begin
      beat_t eb;
      if (rst_n && out_if.tvalid && out_if.tready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got data=%h expected no beat", out_if.tdata);
         end else begin
            eb = sb.pop_front();
            n_chk++;
            if (out_if.tdata !== eb.d) begin
               n_fail++;
               $display("FAIL out_data: got %h expected %h", out_if.tdata, eb.d);
            end
            n_chk++;
            if (out_if.tkeep !== eb.k) begin
               n_fail++;
               $display("FAIL out_keep: got %h expected %h", out_if.tkeep, eb.k);
            end
            n_chk++;
            if (out_if.tlast !== eb.l) begin
               n_fail++;
               $display("FAIL out_last: got %b expected %b", out_if.tlast, eb.l);
            end
            n_chk++;
            if (out_if.tuser_vendor !== eb.u) begin
               n_fail++;
               $display("FAIL out_user: got %h expected %h", out_if.tuser_vendor, eb.u);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one TLP; pushes its expected side-band beats when push is set.
   // max_beats truncates the packet (for mid-packet reset).
   task automatic send_pkt(input logic [255:0] hdr, input logic v, input int nbytes,
                           input bit gaps, input bit push, input int max_beats);
      logic [7:0]    s[$];
      logic [7:0]    pl[$];
      logic [7:0]    bv;
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      beat_t         eb;
      int            nout, nin, idx, cnt;
      for (int i = 0; i < 32; i++) s.push_back(hdr[i*8 +: 8]);
      for (int i = 0; i < nbytes; i++) begin
         bv = 8'($urandom);
         s.push_back(bv);
         pl.push_back(bv);
      end
      nout = (nbytes == 0) ? 1 : (nbytes + KW - 1) / KW;
      if (push) begin
         for (int b = 0; b < nout; b++) begin
            eb.d = '0;
            eb.k = '0;
            for (int j = 0; j < KW; j++) begin
               idx = b * KW + j;
               if (idx < nbytes) begin
                  eb.d[j*8 +: 8] = pl[idx];
                  eb.k[j]        = 1'b1;
               end
            end
            eb.l = (b == nout - 1);
            eb.u = (b == 0) ? {hdr, v} : {256'b0, v};
            sb.push_back(eb);
         end
      end
      nin = (32 + nbytes + KW - 1) / KW;
      if (max_beats < nin) nin = max_beats;
      for (int b = 0; b < nin; b++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < KW; j++) begin
            idx = b * KW + j;
            if (idx < s.size()) begin
               d[j*8 +: 8] = s[idx];
               k[j]        = 1'b1;
            end
         end
         if (gaps && $urandom_range(7) == 0) begin
            in_if.tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_if.tvalid          = 1'b1;
         in_if.tdata           = d;
         in_if.tkeep           = k;
         in_if.tlast           = (idx >= s.size() - 1) && (b == (32 + nbytes + KW - 1) / KW - 1);
         in_if.tuser_vendor[0] = (b == 0) ? v : 1'($urandom);
         cnt = 0;
         @(negedge clk);
         while (!in_if.tready && cnt < 500) begin
            @(negedge clk);
            cnt++;
         end
         if (!in_if.tready) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_handshake: tready stuck at %b, required 1 within 500 cycles", in_if.tready);
         end
         @(posedge clk);
         #1;
      end
      in_if.tvalid = 1'b0;
      in_if.tlast  = 1'b0;
   endtask

   task automatic wait_drain();
      int cnt = 0;
      while (sb.size() != 0 && cnt < 2000) begin
         @(posedge clk);
         cnt++;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand_hdr();
      logic [255:0] h;
      for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
      return h;
   endfunction

   task automatic test_reset();
      rdy_mode = 2;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (out_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tvalid: got %b expected 0", out_if.tvalid);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (in_if.tready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_tready: got %b expected 1", in_if.tready);
      end
      n_chk++;
      if (out_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tvalid_after_release: got %b expected 0", out_if.tvalid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_hdr_only();
      rdy_mode = 2;
      send_pkt(256'hA5A5_0001_0203_0405_0607_0809_0A0B_0C0D_0E0F_1011_1213_1415_1617_1819_1A1B_1C1D,
               1'b1, 0, 1'b0, 1'b1, 99);
      wait_drain();
      n_chk++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL hdr_only_drain: %0d beats outstanding, expected 0", sb.size());
      end
   endtask

   task automatic test_32b();
      rdy_mode = 2;
      send_pkt(rand_hdr(), 1'b0, 32, 1'b0, 1'b1, 99);
      wait_drain();
      n_chk++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL p32_drain: %0d beats outstanding, expected 0", sb.size());
      end
   endtask

   task automatic test_64b_merge();
      rdy_mode = 2;
      send_pkt(rand_hdr(), 1'b1, 64, 1'b0, 1'b1, 99);
      @(negedge clk);
      n_chk++;
      if (in_if.tready !== 1'b1) begin
         n_fail++;
         $display("FAIL p64_no_flush_tready: got %b expected 1", in_if.tready);
      end
      wait_drain();
      n_chk++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL p64_drain: %0d beats outstanding, expected 0", sb.size());
      end
   endtask

   task automatic test_96b_flush();
      rdy_mode = 2;
      send_pkt(rand_hdr(), 1'b1, 96, 1'b0, 1'b1, 99);
      @(negedge clk);
      n_chk++;
      if (in_if.tready !== 1'b0) begin
         n_fail++;
         $display("FAIL p96_flush_tready: got %b expected 0", in_if.tready);
      end
      @(negedge clk);
      n_chk++;
      if (in_if.tready !== 1'b1) begin
         n_fail++;
         $display("FAIL p96_after_flush_tready: got %b expected 1", in_if.tready);
      end
      wait_drain();
      n_chk++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL p96_drain: %0d beats outstanding, expected 0", sb.size());
      end
   endtask

   task automatic test_random();
      rdy_mode = 0;
      for (int i = 0; i < 10000; i++)
         send_pkt(rand_hdr(), 1'($urandom), int'($urandom_range(0, 200)), 1'b1, 1'b1, 99);
      wait_drain();
      rdy_mode = 2;
      n_chk++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL random_drain: %0d beats outstanding, expected 0", sb.size());
      end
   endtask

   task automatic test_reset_mid();
      rdy_mode = 1;
      send_pkt(rand_hdr(), 1'b1, 200, 1'b0, 1'b0, 2);
      n_chk++;
      if (out_if.tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pending_beat: got tvalid %b expected 1", out_if.tvalid);
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_chk++;
      if (out_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_tvalid: got %b expected 0", out_if.tvalid);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      rdy_mode = 0;
      @(posedge clk);
      #1;
      send_pkt(rand_hdr(), 1'b0, 100, 1'b0, 1'b1, 99);
      wait_drain();
      rdy_mode = 2;
      n_chk++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL midrst_next_pkt_drain: %0d beats outstanding, expected 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_hdr_only();
      test_32b();
      test_64b_merge();
      test_96b_flush();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
